clock_div_monitor: RTL
======================

Name: clock_div_monitor

Overview:
Receive-side checker for the team's clock dividers (e.g. clock_div_by5). It takes a divided clock as data, synchronises it into the clk domain, and measures each period and high time in clk cycles. It declares lock after LOCK_CNT consecutive periods equal to EXP_DIV, and flags mismatches and stalls. It sits beside every divider instance as a built-in self-check, and also serves as a bench scoreboard.

Parameters:
EXP_DIV, 5, expected divide ratio in clk cycles per div_in period (>=2)
CW, 8, width of the period and high-time counters
LOCK_CNT, 4, consecutive matching periods required to assert locked (>=1)
SYNC_STAGES, 2, synchroniser depth on div_in (>=2)

Ports:
clk  input  1  system clock; all logic on rising edge
clear_n  input  1  reset, asynchronous, active-low
div_in  input  1  divided clock under test, treated as asynchronous data
period  output  CW  last measured period in clk cycles
high_time  output  CW  synchronised high cycles within that period
meas_valid  output  1  one-cycle pulse when period/high_time update
locked  output  1  ratio confirmed
err  output  1  sticky: a period != EXP_DIV was seen after the first edge
timeout  output  1  no rising edge for 2^CW-1 cycles

Behaviour:
- Reset (clear_n=0, async): period=0, high_time=0, meas_valid=0, locked=0, err=0, timeout=0, state=SEEK, all counters 0, synchroniser flops 0.
- Sync: div_in passes through SYNC_STAGES flops giving s. rise = s & ~s_d. Latency is SYNC_STAGES+1 cycles from a div_in edge to the meas_valid pulse.
- cnt: loads 1 on rise, else cnt+1, saturating at 2^CW-1.
- hcnt: loads 1 on rise, else hcnt+s, saturating.
- FSM states: SEEK, MEASURE, LOCKED.
- SEEK: waits for rise. On rise: cnt=1, hcnt=1, match=0, go to MEASURE, no meas_valid. The first edge after reset or timeout never produces a measurement.
- MEASURE/LOCKED on rise:
  - period<=cnt, high_time<=hcnt, meas_valid=1 for exactly one cycle, timeout<=0.
  - If cnt==EXP_DIV: match<=min(match+1, LOCK_CNT). When match reaches LOCK_CNT, go to LOCKED and assert locked in the same cycle as that meas_valid.
  - Else: match<=0, err<=1 (sticky until reset). If in LOCKED, return to MEASURE and drop locked in the same cycle as meas_valid.
- Stall: if cnt reaches 2^CW-1 without a rise, timeout<=1, locked<=0, match<=0, go to SEEK. period/high_time hold their last values. timeout holds until the next meas_valid.
- div_in stuck high or stuck low produces the same result: timeout.
- Odd-ratio dividers with 50% duty (negedge-generated) sample as high_time floor or ceil of EXP_DIV/2. Both values are legal; high_time is reported only and never affects lock.
- A rise in the same cycle cnt saturates: the rise wins. The measurement is taken with period=2^CW-1, which is a mismatch.
- period >= 2^CW is unrepresentable and is treated as a stall.

Decomposition:
- Package clock_div_pkg:
  - state enum {SEEK, MEASURE, LOCKED}
  - default CW, SYNC_STAGES
  - CNT_MAX constant function of CW
- One sub-module, edge_sync: parameterised SYNC_STAGES synchroniser plus rise detector. Outputs s and rise; reset async active-low via clear_n. The counters and FSM stay in clock_div_monitor.

Test Plan:
- clk 10 ns, clock_div_by5 driving div_in, release both resets at 3 ns → first meas_valid carries period=5, high_time in {2,3}. locked=1 on the 4th meas_valid (about 4x50 ns after the first counted edge); err=0 throughout.
- Divide-by-4 source, EXP_DIV=5 → every meas_valid shows period=4; locked stays 0; err=1 from the first measurement onward.
- Lock achieved, then div_in held low → after 255 cycles without a rise, timeout=1, locked=0, state SEEK. Restart the source → first rise gives no meas_valid, the next gives period=5 and timeout=0; relock after 4 more periods.
- Locked, inject one 3-cycle period → that meas_valid shows period=3, locked=0 in the same cycle, err=1. locked returns after 4 further 5-cycle periods.
- Pull clear_n low mid-period while locked → all outputs 0 immediately, before the next clk edge. After release, the first rise produces no meas_valid.
- SYNC_STAGES=3 → latency from the div_in rising edge to meas_valid is exactly 4 clk cycles.

Source files
------------

// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared types and constants for the divided-clock monitor
package clock_div_pkg;

   typedef enum logic [1:0] {
      SEEK    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam int DEF_CW          = 8;
   localparam int DEF_SYNC_STAGES = 2;

   // Saturation value of a cw-bit period/high-time counter
   function automatic int cnt_max(input int cw);
      return (1 << cw) - 1;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - multi-flop synchroniser with rising-edge detect
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clear_n,
   input  logic d,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sr;
   logic                   s_d;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         sr  <= '0;
         s_d <= 1'b0;
      end else begin
         sr  <= {sr[SYNC_STAGES-2:0], d};
         s_d <= sr[SYNC_STAGES-1];
      end
   end

   assign s    = sr[SYNC_STAGES-1];
   assign rise = s & ~s_d;

endmodule

// File: rtl/clock_div_monitor.sv
// rtl/clock_div_monitor.sv - measures period/high time of a divided clock and tracks lock
module clock_div_monitor
   import clock_div_pkg::*;
#(
   parameter int EXP_DIV     = 5,
   parameter int CW          = DEF_CW,
   parameter int LOCK_CNT    = 4,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic          clk,
   input  logic          clear_n,
   input  logic          div_in,
   output logic [CW-1:0] period,
   output logic [CW-1:0] high_time,
   output logic          meas_valid,
   output logic          locked,
   output logic          err,
   output logic          timeout
);

   localparam logic [CW-1:0] CNT_MAX   = CW'(cnt_max(CW));
   localparam logic [CW-1:0] EXP_CNT   = CW'(EXP_DIV);
   localparam int            MW        = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);

   logic          s;
   logic          rise;
   state_t        state, state_nxt;
   logic [CW-1:0] cnt, hcnt;
   logic [MW-1:0] match, match_nxt;
   logic [CW-1:0] period_nxt, high_nxt;
   logic          meas_nxt, err_nxt, timeout_nxt;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .clear_n(clear_n),
      .d      (div_in),
      .s      (s),
      .rise   (rise)
   );

   // Both counters restart at 1 on the rise itself so a clean period reads exactly EXP_DIV
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         cnt  <= '0;
         hcnt <= '0;
      end else if (rise) begin
         cnt  <= CW'(1);
         hcnt <= CW'(1);
      end else begin
         if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
         if (s && hcnt != CNT_MAX)
            hcnt <= hcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state      <= SEEK;
         match      <= '0;
         period     <= '0;
         high_time  <= '0;
         meas_valid <= 1'b0;
         err        <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         match      <= match_nxt;
         period     <= period_nxt;
         high_time  <= high_nxt;
         meas_valid <= meas_nxt;
         err        <= err_nxt;
         timeout    <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      match_nxt   = match;
      period_nxt  = period;
      high_nxt    = high_time;
      meas_nxt    = 1'b0;
      err_nxt     = err;
      timeout_nxt = timeout;
      case (state)
         SEEK: begin
            // The first edge only opens a window; there is no full period to report yet
            if (rise) begin
               state_nxt = MEASURE;
               match_nxt = '0;
            end
         end
         MEASURE, LOCKED: begin
            if (rise) begin
               meas_nxt    = 1'b1;
               period_nxt  = cnt;
               high_nxt    = hcnt;
               timeout_nxt = 1'b0;
               if (cnt == EXP_CNT) begin
                  if (match != MATCH_MAX)
                     match_nxt = match + 1'b1;
                  if (match_nxt == MATCH_MAX)
                     state_nxt = LOCKED;
               end else begin
                  match_nxt = '0;
                  err_nxt   = 1'b1;
                  state_nxt = MEASURE;
               end
            end else if (cnt == CNT_MAX) begin
               timeout_nxt = 1'b1;
               match_nxt   = '0;
               state_nxt   = SEEK;
            end
         end
         default: state_nxt = SEEK;
      endcase
   end

   assign locked = (state == LOCKED);

endmodule
